// File: rtl/layer2_window_fetch.sv
// ---------------------------------------------------------------------------
// layer2_window_fetch
//
// Purpose:
//   Gathers 3x3 neighbourhoods from the layer-1 result map through the
//   memory read port and presents one full 9-pixel window per valid/ready
//   handshake. Output positions are walked in raster order over the
//   (MAP_WIDTH-2) x (MAP_WIDTH-2) valid-convolution grid.
//
// Optional feature:
//   LAYER2_WINDOW_REUSE_EN - when defined, a column step inside a row shifts
//   the held window left by one column and fetches only the new right-hand
//   column (slots 2, 5, 8). When undefined, every window is fetched in full.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      begins a full-map pass (only honoured in IDLE)
//   read_row_addr/col_addr     map coordinate being read (0 when not reading)
//   layer1_result_read_signal  memory read enable
//   layer1_result_output       memory read data, RD_LAT cycles after issue
//   window_data                9 slots, slot k=r*3+c at [k*DATA_W +: DATA_W]
//   window_valid/window_ready  output handshake
//   out_row, out_col           top-left coordinate of the presented window
//   busy                       high outside IDLE
//   done                       one-cycle pulse after the last window
//
// States:
//   IDLE    | waiting for start
//   FETCH   | issuing one read per cycle
//   DRAIN   | reads in flight, waiting for last capture
//   PRESENT | window held until accepted
//   FINISH  | done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module layer2_window_fetch #(
  parameter int MAP_WIDTH = 30,
  parameter int DATA_W    = 128,
  parameter int RD_LAT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [15:0]         read_row_addr,
  output logic [15:0]         read_col_addr,
  output logic                layer1_result_read_signal,
  input  logic [DATA_W-1:0]   layer1_result_output,
  output logic [9*DATA_W-1:0] window_data,
  output logic                window_valid,
  input  logic                window_ready,
  output logic [15:0]         out_row,
  output logic [15:0]         out_col,
  output logic                busy,
  output logic                done
);

  localparam logic [15:0] LAST_POS = 16'(MAP_WIDTH - 3);
  localparam int          DRAIN_W  = $clog2(RD_LAT + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);
  localparam logic [3:0]  LAST_SLOT = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_row;
  logic [15:0]          r_col;
  logic [3:0]           r_slot;
  logic [DRAIN_W-1:0]   r_drain;
  logic [9*DATA_W-1:0]  r_win;
  logic [RD_LAT-1:0]    r_cap_vld;
  logic [3:0]           r_cap_slot [RD_LAT];
`ifdef LAYER2_WINDOW_REUSE_EN
  logic                 r_reuse;
`endif

  logic                 w_rd;
  logic                 w_valid;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;
  logic [3:0]           w_step;

  function automatic logic [15:0] f_row_off(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: f_row_off = 16'd0;
      4'd3, 4'd4, 4'd5: f_row_off = 16'd1;
      default:          f_row_off = 16'd2;
    endcase
  endfunction

  function automatic logic [15:0] f_col_off(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: f_col_off = 16'd0;
      4'd1, 4'd4, 4'd7: f_col_off = 16'd1;
      default:          f_col_off = 16'd2;
    endcase
  endfunction

  // Slot walk: full fetch steps 0..8; a reuse fetch steps 2,5,8.
`ifdef LAYER2_WINDOW_REUSE_EN
  assign w_step = r_reuse ? 4'd3 : 4'd1;
`else
  assign w_step = 4'd1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_valid     = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_rd = 1'b1;
        if (r_slot == LAST_SLOT) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Read enable stays high: the memory gates its output with it.
        w_rd = 1'b1;
        if (r_drain == DRAIN_LAST) w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        w_valid = 1'b1;
        if (window_ready) begin
          w_accept = 1'b1;
          if (r_col == LAST_POS && r_row == LAST_POS) w_state_nxt = S_FINISH;
          else                                        w_state_nxt = S_FETCH;
        end
      end
      S_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_slot    <= '0;
      r_drain   <= '0;
      r_win     <= '0;
      r_cap_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_cap_slot[i] <= '0;
`ifdef LAYER2_WINDOW_REUSE_EN
      r_reuse   <= 1'b0;
`endif
    end else begin
      // Capture pipeline mirrors the memory latency: the slot issued in
      // cycle t reaches the last stage during cycle t+RD_LAT.
      r_cap_vld[0]  <= (r_state == S_FETCH);
      r_cap_slot[0] <= r_slot;
      for (int i = 1; i < RD_LAT; i++) begin
        r_cap_vld[i]  <= r_cap_vld[i-1];
        r_cap_slot[i] <= r_cap_slot[i-1];
      end
      if (r_cap_vld[RD_LAT-1]) begin
        r_win[int'(r_cap_slot[RD_LAT-1])*DATA_W +: DATA_W] <= layer1_result_output;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row  <= '0;
            r_col  <= '0;
            r_slot <= '0;
`ifdef LAYER2_WINDOW_REUSE_EN
            r_reuse <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          if (r_slot == LAST_SLOT) begin
            r_slot  <= '0;
            r_drain <= '0;
          end else begin
            r_slot <= r_slot + w_step;
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
        end
        S_PRESENT: begin
          if (w_accept) begin
            if (r_col < LAST_POS) begin
              r_col <= r_col + 16'd1;
`ifdef LAYER2_WINDOW_REUSE_EN
              // Pipeline is empty here, so the shift cannot race a capture.
              r_reuse <= 1'b1;
              r_slot  <= 4'd2;
              for (int r = 0; r < 3; r++) begin
                r_win[(r*3+0)*DATA_W +: DATA_W] <= r_win[(r*3+1)*DATA_W +: DATA_W];
                r_win[(r*3+1)*DATA_W +: DATA_W] <= r_win[(r*3+2)*DATA_W +: DATA_W];
              end
`else
              r_slot <= '0;
`endif
            end else if (r_row < LAST_POS) begin
              r_col  <= '0;
              r_row  <= r_row + 16'd1;
              r_slot <= '0;
`ifdef LAYER2_WINDOW_REUSE_EN
              r_reuse <= 1'b0;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign read_row_addr             = (r_state == S_FETCH) ? r_row + f_row_off(r_slot) : 16'd0;
  assign read_col_addr             = (r_state == S_FETCH) ? r_col + f_col_off(r_slot) : 16'd0;
  assign layer1_result_read_signal = w_rd;
  assign window_data               = r_win;
  assign window_valid              = w_valid;
  assign out_row                   = r_row;
  assign out_col                   = r_col;
  assign busy                      = w_busy;
  assign done                      = w_done;

endmodule

// File: tb/tb_layer2_window_fetch.sv
module tb_layer2_window_fetch;

  localparam int MW = 30;
  localparam int DW = 128;
  localparam int RL = 2;
  localparam int NPOS = MW - 2;
`ifdef LAYER2_WINDOW_REUSE_EN
  localparam int REUSE = 1;
`else
  localparam int REUSE = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [15:0]     read_row_addr;
  logic [15:0]     read_col_addr;
  logic            layer1_result_read_signal;
  logic [DW-1:0]   layer1_result_output;
  logic [9*DW-1:0] window_data;
  logic            window_valid;
  logic            window_ready;
  logic [15:0]     out_row;
  logic [15:0]     out_col;
  logic            busy;
  logic            done;

  layer2_window_fetch #(.MAP_WIDTH(MW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .read_row_addr             (read_row_addr),
    .read_col_addr             (read_col_addr),
    .layer1_result_read_signal (layer1_result_read_signal),
    .layer1_result_output      (layer1_result_output),
    .window_data               (window_data),
    .window_valid              (window_valid),
    .window_ready              (window_ready),
    .out_row                   (out_row),
    .out_col                   (out_col),
    .busy                      (busy),
    .done                      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] ent(input int r, input int c);
    logic [7:0] rb;
    logic [7:0] cb;
    rb = 8'(r);
    cb = 8'(c);
    return {8{rb, cb}};
  endfunction

  // Memory model: RL-stage registered read path.
  logic [DW-1:0] mp [RL];
  always @(posedge clk) begin
    mp[0] <= layer1_result_read_signal ? ent(int'(read_row_addr), int'(read_col_addr)) : '0;
    for (int i = 1; i < RL; i++) mp[i] <= mp[i-1];
  end
  assign layer1_result_output = mp[RL-1];

  // Scoreboard + monitor
  int              exp_q [$];
  logic            mon_en = 1'b0;
  int              cyc = 0;
  int              acc_cyc = 0;
  logic            have_acc = 1'b0;
  logic            prev_valid = 1'b0;
  logic            exp_done = 1'b0;
  int              done_cnt = 0;
  logic [15:0]     snap_row;
  logic [15:0]     snap_col;
  logic [9*DW-1:0] snap_win;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (done) done_cnt++;
      if (done || exp_done) begin
        check("done_pulse", 128'(done), 128'(exp_done));
        exp_done = 1'b0;
      end
      if (window_valid) check("no_read_while_valid", 128'(layer1_result_read_signal), 128'd0);
      if (window_valid && !prev_valid) begin
        check("window_expected", 128'(exp_q.size() > 0), 128'd1);
        if (exp_q.size() > 0) begin
          int p, er, ec, per;
          p  = exp_q.pop_front();
          er = p / 256;
          ec = p % 256;
          check("out_row", 128'(out_row), 128'(er));
          check("out_col", 128'(out_col), 128'(ec));
          for (int k = 0; k < 9; k++)
            check($sformatf("slot%0d_r%0d_c%0d", k, er, ec),
                  window_data[k*DW +: DW], ent(er + k/3, ec + k%3));
          if (er == 5 && ec == 7) check("win_5_7_slot4", window_data[4*DW +: DW], {8{16'h0608}});
          if (er == 1 && ec == 0) check("win_1_0_slot0", window_data[0 +: DW], {8{16'h0100}});
          if (have_acc) begin
            per = (ec == 0 || REUSE == 0) ? 12 : 6;
            check($sformatf("period_r%0d_c%0d", er, ec), 128'(cyc - acc_cyc), 128'(per));
          end
        end
        snap_row = out_row;
        snap_col = out_col;
        snap_win = window_data;
      end else if (window_valid) begin
        check("hold_row", 128'(out_row), 128'(snap_row));
        check("hold_col", 128'(out_col), 128'(snap_col));
        check("hold_data", 128'(window_data == snap_win), 128'd1);
      end
      if (window_valid && window_ready) begin
        acc_cyc  = cyc;
        have_acc = 1'b1;
        if (out_row == 16'(NPOS-1) && out_col == 16'(NPOS-1)) exp_done = 1'b1;
      end
      prev_valid = window_valid;
    end
  end

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},  128'(busy), 128'd0);
    check({pfx, "_valid"}, 128'(window_valid), 128'd0);
    check({pfx, "_done"},  128'(done), 128'd0);
    check({pfx, "_rdsig"}, 128'(layer1_result_read_signal), 128'd0);
    check({pfx, "_rdrow"}, 128'(read_row_addr), 128'd0);
    check({pfx, "_rdcol"}, 128'(read_col_addr), 128'd0);
    check({pfx, "_orow"},  128'(out_row), 128'd0);
    check({pfx, "_ocol"},  128'(out_col), 128'd0);
    check({pfx, "_win0"},  128'(window_data == '0), 128'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    window_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    // Reset in the 4th FETCH cycle aborts the pass.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("fetch1_busy", 128'(busy), 128'd1);
    check("fetch1_rdsig", 128'(layer1_result_read_signal), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    check("fetch4_rdcol", 128'(read_col_addr), 128'd0);
    check("fetch4_rdrow", 128'(read_row_addr), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("midrst");
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_done", 128'(done_cnt), 128'd0);
    check("midrst_still_idle", 128'(busy), 128'd0);

    // Full pass with a stall at (0,3) and an ignored start during DRAIN of (2,2).
    for (int r = 0; r < NPOS; r++)
      for (int c = 0; c < NPOS; c++)
        exp_q.push_back(r*256 + c);
    window_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    fork
      begin : stall_drv
        int n;
        n = 0;
        while (!(out_row == 16'd0 && out_col == 16'd3 && !window_valid) && n < 2000) begin
          @(posedge clk); #1; n++;
        end
        check("stall_reached", 128'(n < 2000), 128'd1);
        window_ready = 1'b0;
        n = 0;
        while (!window_valid && n < 100) begin
          @(posedge clk); #1; n++;
        end
        check("stall_window_seen", 128'(window_valid), 128'd1);
        repeat (20) @(posedge clk);
        #1;
        check("stall_still_0_3", 128'({out_row, out_col}), 128'({16'd0, 16'd3}));
        window_ready = 1'b1;
      end
      begin : start_drv
        int n;
        n = 0;
        while (!(out_row == 16'd2 && out_col == 16'd2 && layer1_result_read_signal) && n < 5000) begin
          @(posedge clk); #1; n++;
        end
        check("drain_2_2_reached", 128'(n < 5000), 128'd1);
        repeat ((REUSE != 0) ? 3 : 9) @(posedge clk);
        #1;
        check("drain_2_2_no_valid", 128'(window_valid), 128'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      begin : wait_done
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
          @(posedge clk); n++;
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    check("pass_done_count", 128'(done_cnt), 128'd1);
    check("all_windows_seen", 128'(exp_q.size()), 128'd0);
    check("final_busy", 128'(busy), 128'd0);
    check("final_rdsig", 128'(layer1_result_read_signal), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer2_window_fetch.md
# layer2_window_fetch

Sequencer between the layer-1 result memory and the layer-2 convolution datapath. After layer 1 has filled its 30×30 result map (each entry 128 bits, 8 channels × 16 bits), this block drives the memory's read port to gather each 3×3 neighbourhood. It then presents one complete 9-pixel window per valid/ready handshake, walking the 28×28 valid-convolution output positions in raster order.

## Interface
Parameters:
- MAP_WIDTH, 30, side of the stored layer-1 map; the output grid is (MAP_WIDTH-2)².
- DATA_W, 128, width of one stored map entry.
- RD_LAT, 2, cycles from address/read-signal issue to data at the memory output.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a full-map pass; ignored unless the block is idle.
- read_row_addr  out  16  row of the map entry being read.
- read_col_addr  out  16  column of the map entry being read.
- layer1_result_read_signal  out  1  read enable to the result memory.
- layer1_result_output  in  DATA_W  memory read data, valid RD_LAT cycles after issue.
- window_data  out  9*DATA_W  window; slot k=r*3+c occupies bits [k*DATA_W +: DATA_W], with r and c as the row and column offsets.
- window_valid  out  1  window_data, out_row and out_col are valid.
- window_ready  in  1  downstream accepts the window on a cycle where window_valid is also high.
- out_row, out_col  out  16 each  top-left map coordinate of the presented window.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window (27,27) is accepted.

## Operation
FSM states: IDLE, FETCH, DRAIN, PRESENT, FINISH.
- **IDLE.** On start, load position (0,0), clear the issue counter, and go to FETCH.
- **FETCH.** Issue one read per cycle, with layer1_result_read_signal high.
  - Full fetch issues slots k=0..8 in order, at address (out_row+k/3, out_col+k%3).
  - After the last issue, go to DRAIN.
- **Capture.** A capture counter delayed by RD_LAT from the issue counter writes layer1_result_output into the matching slot.
- **DRAIN.** Hold layer1_result_read_signal high; the memory gates its output with this signal. Stay here for RD_LAT cycles until the last slot is captured, then go to PRESENT.
- **PRESENT.** layer1_result_read_signal is low and window_valid is high. window_data, out_row and out_col stay stable until window_ready.
- **On accept**, advance the position:
  - If out_col < MAP_WIDTH-3: out_col+1.
  - Otherwise, if out_row < MAP_WIDTH-3: out_col=0 and out_row+1, then go to FETCH.
  - After (27,27): go to FINISH.
- **FINISH.** Pulse done for one cycle, then return to IDLE.
- **Idle outputs.** read_row_addr and read_col_addr are 0 whenever layer1_result_read_signal is low.
- **Address arithmetic.** Addresses are 16-bit unsigned and never exceed MAP_WIDTH-1. The memory performs the row*MAP_WIDTH+col mapping.

## Timing
- **Reset values.** All outputs are 0 and the state is IDLE. window_data is all zeros.
- **Reset mid-pass.** Abandon the pass. No done pulse.
- **Read latency.** An address issued in cycle t is captured at the end of cycle t+RD_LAT.
- **Full-fetch window period.** 9 issue + RD_LAT drain + 1 present = 12 cycles minimum with window_ready held high.
- **Start.** start in cycle t puts the first read issue in cycle t+1.
- **Accept.** window_valid && window_ready at edge e starts the next FETCH issue in the cycle after e. window_valid falls at e.
- **Ignored start.** start is ignored while busy, including the cycle of the done pulse.
- **Handshake rule.** window_ready while window_valid is low has no effect.

## Configuration
- **LAYER2_WINDOW_REUSE_EN defined.**
  - On accept with a column advance inside a row, shift the window: slots c=0←1 and c=1←2 for each row r.
  - Then fetch only slots 2, 5 and 8, at column out_col+2.
  - Window period becomes 3+RD_LAT+1 = 6 cycles.
  - The first window of each row still uses a full 9-read fetch.
- **Undefined.** Every window uses a full 9-read fetch, and the shift logic is absent.
- **Both modes.** window_data content per position is identical either way.

## Test plan
- **Full pass.** Fill the memory model with entry(r,c)={8{r[7:0],c[7:0]}}, pulse start, hold window_ready=1.
  - 784 windows arrive in raster order.
  - Window (5,7) slot 4 = {8{16'h0608}}.
  - done pulses once, after window (27,27).
- **Period.** With window_ready held high, consecutive window_valid rises are 12 cycles apart (6 within a row with LAYER2_WINDOW_REUSE_EN).
  - The first window in each row is always 12 cycles.
- **Back-pressure.** Hold window_ready=0 for 20 cycles at window (0,3).
  - window_data, out_row and out_col stay constant.
  - No read issued during stall.
  - The next window is (0,4).
- **Row wrap.** Accept window (0,27). The next is (1,0) with a full 9-read fetch and slot 0 = {8{16'h0100}}.
- **Reset mid-fetch.** Assert rst in the 4th FETCH cycle.
  - Next cycle: all outputs 0 and busy=0.
  - A new start restarts at (0,0).
- **Start while busy.** Pulse start during DRAIN of window (2,2). There is no effect on the sequence or the window count.
